// File: rtl/rmt_decode_pipe_if.sv
// Bundled request/response signals between the decode stage and its driver.
// RMT_DECODE_RANGE_CHK_EN adds the sticky range_err_o flag.
interface rmt_decode_pipe_if #(
    parameter int SRAM_DEPTH = 64,
    parameter int SRAM_INDEX = 6,
    parameter int SRAM_WIDTH = 8
);
    logic                  stall_i;
    logic                  flush_i;
    logic [SRAM_INDEX-1:0] addr0_i, addr1_i, addr2_i, addr3_i;
    logic                  rden0_i, rden1_i, rden2_i, rden3_i;
    logic [SRAM_INDEX-1:0] addr0wr_i, addr1wr_i;
    logic                  we0_i, we1_i;
    logic [SRAM_WIDTH-1:0] data0wr_i, data1wr_i;

    logic [SRAM_DEPTH-1:0] decoded_addr0_o, decoded_addr1_o, decoded_addr2_o, decoded_addr3_o;
    logic [SRAM_DEPTH-1:0] decoded_addr0wr_o, decoded_addr1wr_o;
    logic                  we0_o, we1_o;
    logic [SRAM_WIDTH-1:0] data0wr_o, data1wr_o;
    logic                  bypass_hit0_o, bypass_hit1_o, bypass_hit2_o, bypass_hit3_o;
    logic [SRAM_WIDTH-1:0] bypass_data0_o, bypass_data1_o, bypass_data2_o, bypass_data3_o;
    logic [7:0]            wr_conflict_cnt_o;
`ifdef RMT_DECODE_RANGE_CHK_EN
    logic                  range_err_o;
`endif

    modport master (
        output stall_i, flush_i,
        output addr0_i, addr1_i, addr2_i, addr3_i,
        output rden0_i, rden1_i, rden2_i, rden3_i,
        output addr0wr_i, addr1wr_i, we0_i, we1_i, data0wr_i, data1wr_i,
        input  decoded_addr0_o, decoded_addr1_o, decoded_addr2_o, decoded_addr3_o,
        input  decoded_addr0wr_o, decoded_addr1wr_o, we0_o, we1_o, data0wr_o, data1wr_o,
        input  bypass_hit0_o, bypass_hit1_o, bypass_hit2_o, bypass_hit3_o,
        input  bypass_data0_o, bypass_data1_o, bypass_data2_o, bypass_data3_o,
`ifdef RMT_DECODE_RANGE_CHK_EN
        input  range_err_o,
`endif
        input  wr_conflict_cnt_o
    );

    modport slave (
        input  stall_i, flush_i,
        input  addr0_i, addr1_i, addr2_i, addr3_i,
        input  rden0_i, rden1_i, rden2_i, rden3_i,
        input  addr0wr_i, addr1wr_i, we0_i, we1_i, data0wr_i, data1wr_i,
        output decoded_addr0_o, decoded_addr1_o, decoded_addr2_o, decoded_addr3_o,
        output decoded_addr0wr_o, decoded_addr1wr_o, we0_o, we1_o, data0wr_o, data1wr_o,
        output bypass_hit0_o, bypass_hit1_o, bypass_hit2_o, bypass_hit3_o,
        output bypass_data0_o, bypass_data1_o, bypass_data2_o, bypass_data3_o,
`ifdef RMT_DECODE_RANGE_CHK_EN
        output range_err_o,
`endif
        output wr_conflict_cnt_o
    );
endinterface

// File: rtl/rmt_decode_pipe.sv
// Registered address decode stage in front of the 4R/2W decoded-address SRAM.
// Optional sticky index range check enabled by RMT_DECODE_RANGE_CHK_EN.
module rmt_decode_pipe #(
    parameter int SRAM_DEPTH = 64,
    parameter int SRAM_INDEX = 6,
    parameter int SRAM_WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    rmt_decode_pipe_if.slave   bus
);
    localparam int NR = 4;
    localparam int NW = 2;

    function automatic logic in_range(input logic [SRAM_INDEX-1:0] idx);
        return 32'(idx) < 32'(SRAM_DEPTH);
    endfunction

    function automatic logic [SRAM_DEPTH-1:0] onehot(input logic en, input logic [SRAM_INDEX-1:0] idx);
        logic [SRAM_DEPTH-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < SRAM_DEPTH; i++) begin
            r[i] = en && (32'(idx) == i);
        end
        return r;
    endfunction

    logic [SRAM_INDEX-1:0] addr_in  [NR];
    logic [NR-1:0]         rden_in;
    logic [SRAM_INDEX-1:0] awr_in   [NW];
    logic [NW-1:0]         we_in;
    logic [SRAM_WIDTH-1:0] dwr_in   [NW];

    logic [SRAM_INDEX-1:0] addr_q   [NR];
    logic [SRAM_INDEX-1:0] addr_d   [NR];
    logic [NR-1:0]         rden_q, rden_d;
    logic [SRAM_INDEX-1:0] addrwr_q [NW];
    logic [SRAM_INDEX-1:0] addrwr_d [NW];
    logic [NW-1:0]         we_q, we_d;
    logic [SRAM_WIDTH-1:0] datawr_q [NW];
    logic [SRAM_WIDTH-1:0] datawr_d [NW];
    logic [7:0]            cnt_q, cnt_d;

    logic [NR-1:0]         rden_ld;
    logic [NW-1:0]         we_ld;
    logic [NW-1:0]         wr_ok;
    logic [NW-1:0]         we_out;
    logic                  conflict;
    logic [SRAM_DEPTH-1:0] dec_rd   [NR];
    logic [SRAM_DEPTH-1:0] dec_wr   [NW];
    logic [NR-1:0]         hit;
    logic [SRAM_WIDTH-1:0] bdata    [NR];

    always_comb begin
        addr_in[0] = bus.addr0_i;  addr_in[1] = bus.addr1_i;
        addr_in[2] = bus.addr2_i;  addr_in[3] = bus.addr3_i;
        rden_in    = {bus.rden3_i, bus.rden2_i, bus.rden1_i, bus.rden0_i};
        awr_in[0]  = bus.addr0wr_i; awr_in[1] = bus.addr1wr_i;
        we_in      = {bus.we1_i, bus.we0_i};
        dwr_in[0]  = bus.data0wr_i; dwr_in[1] = bus.data1wr_i;
    end

`ifdef RMT_DECODE_RANGE_CHK_EN
    logic range_err_q, range_err_d;
    logic range_set;

    // Out-of-range ports are dropped at load so they never reach the SRAM.
    always_comb begin
        range_set = 1'b0;
        for (int unsigned n = 0; n < NR; n++) begin
            rden_ld[n] = rden_in[n] & in_range(addr_in[n]);
            range_set  = range_set | (rden_in[n] & ~in_range(addr_in[n]));
        end
        for (int unsigned m = 0; m < NW; m++) begin
            we_ld[m]  = we_in[m] & in_range(awr_in[m]);
            range_set = range_set | (we_in[m] & ~in_range(awr_in[m]));
        end
    end

    always_comb begin
        range_err_d = range_err_q;
        if (!bus.flush_i && !bus.stall_i) begin
            range_err_d = range_err_q | range_set;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) range_err_q <= 1'b0;
        else        range_err_q <= range_err_d;
    end

    assign bus.range_err_o = range_err_q;
`else
    always_comb begin
        rden_ld = rden_in;
        we_ld   = we_in;
    end
`endif

    always_comb begin
        addr_d   = addr_q;
        rden_d   = rden_q;
        addrwr_d = addrwr_q;
        we_d     = we_q;
        datawr_d = datawr_q;
        cnt_d    = cnt_q;
        if (bus.flush_i) begin
            rden_d = '0;
            we_d   = '0;
        end else if (!bus.stall_i) begin
            addr_d   = addr_in;
            rden_d   = rden_ld;
            addrwr_d = awr_in;
            we_d     = we_ld;
            datawr_d = dwr_in;
            if (conflict && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_q   <= '{default: '0};
            rden_q   <= '0;
            addrwr_q <= '{default: '0};
            we_q     <= '0;
            datawr_q <= '{default: '0};
            cnt_q    <= '0;
        end else begin
            addr_q   <= addr_d;
            rden_q   <= rden_d;
            addrwr_q <= addrwr_d;
            we_q     <= we_d;
            datawr_q <= datawr_d;
            cnt_q    <= cnt_d;
        end
    end

    // A write whose index lies past the array end never conflicts or forwards.
    always_comb begin
        for (int unsigned m = 0; m < NW; m++) begin
            wr_ok[m] = we_q[m] & in_range(addrwr_q[m]);
        end
        conflict  = wr_ok[0] & wr_ok[1] & (addrwr_q[0] == addrwr_q[1]);
        we_out[0] = we_q[0] & ~conflict;
        we_out[1] = we_q[1];
        for (int unsigned m = 0; m < NW; m++) begin
            dec_wr[m] = onehot(we_out[m], addrwr_q[m]);
        end
        for (int unsigned n = 0; n < NR; n++) begin
            logic h0, h1;
            dec_rd[n] = onehot(rden_q[n], addr_q[n]);
            h1 = rden_q[n] & we_out[1] & wr_ok[1] & (addr_q[n] == addrwr_q[1]);
            h0 = rden_q[n] & we_out[0] & wr_ok[0] & (addr_q[n] == addrwr_q[0]);
            hit[n]   = h0 | h1;
            bdata[n] = h1 ? datawr_q[1] : (h0 ? datawr_q[0] : '0);
        end
    end

    assign bus.decoded_addr0_o   = dec_rd[0];
    assign bus.decoded_addr1_o   = dec_rd[1];
    assign bus.decoded_addr2_o   = dec_rd[2];
    assign bus.decoded_addr3_o   = dec_rd[3];
    assign bus.decoded_addr0wr_o = dec_wr[0];
    assign bus.decoded_addr1wr_o = dec_wr[1];
    assign bus.we0_o             = we_out[0];
    assign bus.we1_o             = we_out[1];
    assign bus.data0wr_o         = datawr_q[0];
    assign bus.data1wr_o         = datawr_q[1];
    assign bus.bypass_hit0_o     = hit[0];
    assign bus.bypass_hit1_o     = hit[1];
    assign bus.bypass_hit2_o     = hit[2];
    assign bus.bypass_hit3_o     = hit[3];
    assign bus.bypass_data0_o    = bdata[0];
    assign bus.bypass_data1_o    = bdata[1];
    assign bus.bypass_data2_o    = bdata[2];
    assign bus.bypass_data3_o    = bdata[3];
    assign bus.wr_conflict_cnt_o = cnt_q;
endmodule

// File: tb/tb_rmt_decode_pipe.sv
// Directed, table-driven bench for rmt_decode_pipe (also covers RMT_DECODE_RANGE_CHK_EN).
module tb_rmt_decode_pipe;
`ifdef RMT_DECODE_RANGE_CHK_EN
    localparam int DEPTH = 48;
`else
    localparam int DEPTH = 64;
`endif

    typedef struct packed {
        logic                   stall;
        logic                   flush;
        logic [3:0]             rden;
        logic [3:0][5:0]        addr;
        logic [1:0]             we;
        logic [1:0][5:0]        awr;
        logic [1:0][7:0]        dwr;
        logic [3:0][DEPTH-1:0]  x_dec;
        logic [1:0][DEPTH-1:0]  x_decwr;
        logic [1:0]             x_we;
        logic                   chk_data;
        logic [1:0][7:0]        x_dwo;
        logic [3:0]             x_hit;
        logic [3:0][7:0]        x_bdata;
        logic [7:0]             x_cnt;
    } vec_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    rmt_decode_pipe_if #(.SRAM_DEPTH(DEPTH), .SRAM_INDEX(6), .SRAM_WIDTH(8)) bus ();
    rmt_decode_pipe #(.SRAM_DEPTH(DEPTH), .SRAM_INDEX(6), .SRAM_WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.stall_i   = v.stall;     bus.flush_i   = v.flush;
        bus.rden0_i   = v.rden[0];   bus.rden1_i   = v.rden[1];
        bus.rden2_i   = v.rden[2];   bus.rden3_i   = v.rden[3];
        bus.addr0_i   = v.addr[0];   bus.addr1_i   = v.addr[1];
        bus.addr2_i   = v.addr[2];   bus.addr3_i   = v.addr[3];
        bus.we0_i     = v.we[0];     bus.we1_i     = v.we[1];
        bus.addr0wr_i = v.awr[0];    bus.addr1wr_i = v.awr[1];
        bus.data0wr_i = v.dwr[0];    bus.data1wr_i = v.dwr[1];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input vec_t v);
        cmp({tag, ".dec0"},   64'(bus.decoded_addr0_o),   64'(v.x_dec[0]));
        cmp({tag, ".dec1"},   64'(bus.decoded_addr1_o),   64'(v.x_dec[1]));
        cmp({tag, ".dec2"},   64'(bus.decoded_addr2_o),   64'(v.x_dec[2]));
        cmp({tag, ".dec3"},   64'(bus.decoded_addr3_o),   64'(v.x_dec[3]));
        cmp({tag, ".decwr0"}, 64'(bus.decoded_addr0wr_o), 64'(v.x_decwr[0]));
        cmp({tag, ".decwr1"}, 64'(bus.decoded_addr1wr_o), 64'(v.x_decwr[1]));
        cmp({tag, ".we_o"},   64'({bus.we1_o, bus.we0_o}), 64'(v.x_we));
        if (v.chk_data) begin
            cmp({tag, ".dwo0"}, 64'(bus.data0wr_o), 64'(v.x_dwo[0]));
            cmp({tag, ".dwo1"}, 64'(bus.data1wr_o), 64'(v.x_dwo[1]));
        end
        cmp({tag, ".hit"}, 64'({bus.bypass_hit3_o, bus.bypass_hit2_o, bus.bypass_hit1_o, bus.bypass_hit0_o}),
            64'(v.x_hit));
        cmp({tag, ".bdata0"}, 64'(bus.bypass_data0_o), 64'(v.x_bdata[0]));
        cmp({tag, ".bdata1"}, 64'(bus.bypass_data1_o), 64'(v.x_bdata[1]));
        cmp({tag, ".bdata2"}, 64'(bus.bypass_data2_o), 64'(v.x_bdata[2]));
        cmp({tag, ".bdata3"}, 64'(bus.bypass_data3_o), 64'(v.x_bdata[3]));
        cmp({tag, ".cnt"},    64'(bus.wr_conflict_cnt_o), 64'(v.x_cnt));
    endtask

    vec_t tbl [9];
    vec_t v;

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 9; i++) tbl[i] = '0;

        // t0: read port 2 index 5
        tbl[0].rden[2] = 1'b1; tbl[0].addr[2] = 6'd5;
        tbl[0].x_dec[2] = 'h20; tbl[0].chk_data = 1'b1;
        // t1: same index, port disabled
        tbl[1].addr[2] = 6'd5; tbl[1].chk_data = 1'b1;
        // t2: write-write conflict on index 9, port 1 wins
        tbl[2].we = 2'b11; tbl[2].awr[0] = 6'd9; tbl[2].awr[1] = 6'd9;
        tbl[2].dwr[0] = 8'hAA; tbl[2].dwr[1] = 8'h55;
        tbl[2].x_decwr[1] = 'h200; tbl[2].x_we = 2'b10;
        tbl[2].chk_data = 1'b1; tbl[2].x_dwo[0] = 8'hAA; tbl[2].x_dwo[1] = 8'h55;
        // t3: conflict held; counter reflects the previous edge's conflict
        tbl[3] = tbl[2]; tbl[3].x_cnt = 8'd1;
        // t4: read/write same index via port 0
        tbl[4].rden[0] = 1'b1; tbl[4].addr[0] = 6'd3;
        tbl[4].we = 2'b01; tbl[4].awr[0] = 6'd3; tbl[4].dwr[0] = 8'h3C;
        tbl[4].x_dec[0] = 'h8; tbl[4].x_decwr[0] = 'h8; tbl[4].x_we = 2'b01;
        tbl[4].chk_data = 1'b1; tbl[4].x_dwo[0] = 8'h3C;
        tbl[4].x_hit = 4'b0001; tbl[4].x_bdata[0] = 8'h3C; tbl[4].x_cnt = 8'd2;
        // t5: both write ports on index 3, forward from port 1
        tbl[5] = tbl[4];
        tbl[5].we = 2'b11; tbl[5].awr[1] = 6'd3; tbl[5].dwr[1] = 8'hC3;
        tbl[5].x_decwr[0] = '0; tbl[5].x_decwr[1] = 'h8; tbl[5].x_we = 2'b10;
        tbl[5].x_dwo[1] = 8'hC3; tbl[5].x_bdata[0] = 8'hC3;
        // t6: distinct writes, each forwarded to two readers
        tbl[6].rden = 4'b1111;
        tbl[6].addr[0] = 6'd10; tbl[6].addr[1] = 6'd20; tbl[6].addr[2] = 6'd10; tbl[6].addr[3] = 6'd20;
        tbl[6].we = 2'b11; tbl[6].awr[0] = 6'd10; tbl[6].awr[1] = 6'd20;
        tbl[6].dwr[0] = 8'h11; tbl[6].dwr[1] = 8'h22;
        tbl[6].x_dec[0] = 'h400; tbl[6].x_dec[1] = 'h10_0000; tbl[6].x_dec[2] = 'h400; tbl[6].x_dec[3] = 'h10_0000;
        tbl[6].x_decwr[0] = 'h400; tbl[6].x_decwr[1] = 'h10_0000; tbl[6].x_we = 2'b11;
        tbl[6].chk_data = 1'b1; tbl[6].x_dwo[0] = 8'h11; tbl[6].x_dwo[1] = 8'h22;
        tbl[6].x_hit = 4'b1111;
        tbl[6].x_bdata[0] = 8'h11; tbl[6].x_bdata[1] = 8'h22; tbl[6].x_bdata[2] = 8'h11; tbl[6].x_bdata[3] = 8'h22;
        tbl[6].x_cnt = 8'd3;
        // t7: boundary indices 0 and 47
        tbl[7].rden = 4'b1100; tbl[7].addr[2] = 6'd0; tbl[7].addr[3] = 6'd47;
        tbl[7].we = 2'b11; tbl[7].awr[0] = 6'd47; tbl[7].awr[1] = 6'd0;
        tbl[7].dwr[0] = 8'hF0; tbl[7].dwr[1] = 8'h0F;
        tbl[7].x_dec[2] = 'h1; tbl[7].x_dec[3] = 'h8000_0000_0000;
        tbl[7].x_decwr[0] = 'h8000_0000_0000; tbl[7].x_decwr[1] = 'h1; tbl[7].x_we = 2'b11;
        tbl[7].chk_data = 1'b1; tbl[7].x_dwo[0] = 8'hF0; tbl[7].x_dwo[1] = 8'h0F;
        tbl[7].x_hit = 4'b1100; tbl[7].x_bdata[2] = 8'h0F; tbl[7].x_bdata[3] = 8'hF0;
        tbl[7].x_cnt = 8'd3;
        // t8: flush with everything valid -> all enables cleared
        tbl[8].flush = 1'b1; tbl[8].rden = 4'b1111;
        tbl[8].addr[0] = 6'd1; tbl[8].addr[1] = 6'd2; tbl[8].addr[2] = 6'd3; tbl[8].addr[3] = 6'd4;
        tbl[8].we = 2'b11; tbl[8].awr[0] = 6'd5; tbl[8].awr[1] = 6'd5;
        tbl[8].x_cnt = 8'd3;

        // Reset held two cycles with live enables
        v = '0; v.rden[0] = 1'b1; v.we[0] = 1'b1; v.addr[0] = 6'd3; v.awr[0] = 6'd3; v.dwr[0] = 8'h77;
        drive(v);
        reset = 1'b0;
        step(); step();
        v = '0; v.chk_data = 1'b1;
        check("reset", v);
        drive(v);
        reset = 1'b1;

        for (int i = 0; i < 9; i++) begin
            drive(tbl[i]);
            step();
            check($sformatf("t%0d", i), tbl[i]);
        end

        // Stall: load port 1 index 7 alongside a conflict, then hold it
        v = '0; v.rden[1] = 1'b1; v.addr[1] = 6'd7;
        v.we = 2'b11; v.awr[0] = 6'd9; v.awr[1] = 6'd9; v.dwr[0] = 8'hAA; v.dwr[1] = 8'h55;
        v.x_dec[1] = 'h80; v.x_decwr[1] = 'h200; v.x_we = 2'b10;
        v.chk_data = 1'b1; v.x_dwo[0] = 8'hAA; v.x_dwo[1] = 8'h55; v.x_cnt = 8'd3;
        drive(v);
        step();
        check("stall_load", v);
        for (int i = 0; i < 3; i++) begin
            vec_t s;
            s = v;
            s.stall = 1'b1; s.rden = 4'(i + 1); s.addr[1] = 6'(8 + i); s.awr[1] = 6'(12 + i);
            s.dwr[1] = 8'(i);
            drive(s);
            step();
            check($sformatf("stall%0d", i), v);
        end
        v = '0; v.stall = 1'b1; v.flush = 1'b1; v.rden = 4'b1111; v.we = 2'b11;
        v.x_cnt = 8'd3;
        drive(v);
        step();
        check("stall_flush", v);

        // Saturation: 300 consecutive conflicting loads
        v = '0; v.we = 2'b11; v.awr[0] = 6'd9; v.awr[1] = 6'd9;
        drive(v);
        for (int i = 0; i < 300; i++) begin
            step();
            if (i == 0) cmp("sat_first", 64'(bus.wr_conflict_cnt_o), 64'd3);
            if (i == 1) cmp("sat_second", 64'(bus.wr_conflict_cnt_o), 64'd4);
        end
        cmp("sat_255", 64'(bus.wr_conflict_cnt_o), 64'd255);
        step();
        cmp("sat_hold", 64'(bus.wr_conflict_cnt_o), 64'd255);

        reset = 1'b0;
        step();
        cmp("rst_cnt", 64'(bus.wr_conflict_cnt_o), 64'd0);
        cmp("rst_we", 64'({bus.we1_o, bus.we0_o}), 64'd0);
        reset = 1'b1;

`ifdef RMT_DECODE_RANGE_CHK_EN
        v = '0; v.rden[0] = 1'b1; v.addr[0] = 6'd50; v.we = 2'b01; v.awr[0] = 6'd50;
        drive(v);
        step();
        cmp("rng_dec0", 64'(bus.decoded_addr0_o), 64'd0);
        cmp("rng_we0", 64'(bus.we0_o), 64'd0);
        cmp("rng_err", 64'(bus.range_err_o), 64'd1);
        v = '0; v.rden[1] = 1'b1; v.addr[1] = 6'd2;
        drive(v);
        step(); step();
        cmp("rng_sticky", 64'(bus.range_err_o), 64'd1);
        cmp("rng_dec1", 64'(bus.decoded_addr1_o), 64'h4);
        reset = 1'b0;
        step();
        cmp("rng_clear", 64'(bus.range_err_o), 64'd0);
        reset = 1'b1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rmt_decode_pipe.md
Name: rmt_decode_pipe

Overview:
Pipeline stage directly upstream of the multi-ported decoded-address SRAM (4 read ports, 2 write ports). It registers binary read and write indices plus write data, then drives one-hot decoded addresses and write enables into the SRAM. It also resolves same-index write-write conflicts and flags same-cycle read-after-write hazards with bypass data. Supports stall (hold) and flush (squash).

Parameters:
SRAM_DEPTH, 64, number of SRAM entries (width of one-hot outputs)
SRAM_INDEX, 6, binary index width; SRAM_DEPTH <= 2**SRAM_INDEX
SRAM_WIDTH, 8, entry data width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous reset, active-low (asserted when 0)
stall_i  in  1  hold stage contents
flush_i  in  1  squash stage contents
addrN_i (N=0..3)  in  SRAM_INDEX  binary read index, port N
rdenN_i (N=0..3)  in  1  read-port-N valid
addrMwr_i (M=0,1)  in  SRAM_INDEX  binary write index, port M
weM_i (M=0,1)  in  1  write-port-M enable
dataMwr_i (M=0,1)  in  SRAM_WIDTH  write data, port M
decoded_addrN_o (N=0..3)  out  SRAM_DEPTH  one-hot read address to SRAM
decoded_addrMwr_o (M=0,1)  out  SRAM_DEPTH  one-hot write address to SRAM
weM_o (M=0,1)  out  1  write enable to SRAM, after conflict resolution
dataMwr_o (M=0,1)  out  SRAM_WIDTH  registered write data
bypass_hitN_o (N=0..3)  out  1  read port N hits a write issued this cycle
bypass_dataN_o (N=0..3)  out  SRAM_WIDTH  forwarded write data for port N
wr_conflict_cnt_o  out  8  saturating count of resolved write-write conflicts

Behaviour:
- State: stage registers addr_q/rden_q (x4), addrwr_q/we_q/datawr_q (x2), and an 8-bit conflict counter.
- Reset (reset==0 at edge): all registers cleared. All outputs read 0 the cycle after reset.
- Update priority at each edge: reset > flush_i > stall_i > load.
- flush_i=1: clear rden_q and we_q. Address and data registers are don't-care. Overrides stall_i.
- stall_i=1 (no flush): all registers hold. Outputs are unchanged.
- Otherwise: load all inputs. Latency is exactly 1 cycle from input to decoded outputs.
- decoded_addrN_o = rden_q[N] ? (1 << addr_q[N]) : 0.
- decoded_addrMwr_o = we_q[M] ? (1 << addrwr_q[M]) : 0.
- All outputs are combinational functions of registered state only. There is no input-to-output combinational path.
- Write conflict: if we_q[0] & we_q[1] & addrwr_q[0]==addrwr_q[1], then we0_o=0 and decoded_addr0wr_o=0. Port 1 wins. Otherwise weM_o = we_q[M].
- Conflict counter: increments by 1 on an edge where a conflict is present and stall_i=0, flush_i=0, reset=1. Saturates at 255 (no wrap).
- Bypass for port N: hit1 = rden_q[N] & we1_o & addr_q[N]==addrwr_q[1]; hit0 is the same using port 0 and we0_o.
  - bypass_hitN_o = hit0 | hit1.
  - bypass_dataN_o = hit1 ? datawr_q[1] : hit0 ? datawr_q[0] : 0.
- Index >= SRAM_DEPTH (only possible when SRAM_DEPTH < 2**SRAM_INDEX): the decoded output is all-zero, and such a write never conflicts or bypasses.

Optional Feature:
RMT_DECODE_RANGE_CHK_EN.
- Defined: adds output range_err_o (1 bit, sticky). It sets when a loaded index (valid port) is >= SRAM_DEPTH and clears only on reset. The offending port's enable is suppressed at load.
- Undefined: no range_err_o port. Behaviour is as above.

Test Plan:
- Reset: hold reset=0 for 2 cycles with rden0_i=1, we0_i=1 -> all decoded/we/bypass outputs 0 and wr_conflict_cnt_o=0 after release.
- Decode latency: cycle t rden2_i=1, addr2_i=5 -> cycle t+1 decoded_addr2_o=64'h20. With rden2_i=0 -> 0.
- Conflict: we0_i=we1_i=1, addr0wr_i=addr1wr_i=9, data 8'hAA/8'h55 -> we0_o=0, we1_o=1, decoded_addr1wr_o bit 9, counter=1. Repeat 300 times -> counter saturates at 255.
- Bypass: rden0_i=1, addr0_i=3, we0_i=1, addr0wr_i=3, data0wr_i=8'h3C -> next cycle bypass_hit0_o=1, bypass_data0_o=8'h3C. With both write ports hitting index 3 -> data from port 1.
- Stall/flush: load addr1_i=7, rden1_i=1, then stall_i=1 for 3 cycles with changing inputs -> decoded_addr1_o stays bit 7 and counter frozen. Then stall_i=1 with flush_i=1 -> all enables 0 next cycle.
- With RMT_DECODE_RANGE_CHK_EN and SRAM_DEPTH=48: rden0_i=1, addr0_i=50 -> decoded_addr0_o=0, range_err_o=1 and held until reset.
